// File: rtl/cnn_pkg.sv
// Shared definitions for the CNN back end (dense layer -> packer -> classifier).
//  DATA_WIDTH : width of one signed logit
//  NODES      : logits per frame (number of fault classes)
//  CNT_W      : beat counter width, >= clog2(NODES)
//  packer_state_e : logit packer FSM states
//  slot_offset()  : bit offset of beat k inside a packed frame (beat 0 is the MS slot)
package cnn_pkg;

  localparam int DATA_WIDTH = 16;
  localparam int NODES      = 10;
  localparam int CNT_W      = 4;

  typedef enum logic [0:0] {
    FILL = 1'b0,
    WAIT = 1'b1
  } packer_state_e;

  // Beat k lands at (nodes-1-k)*dw so that beat 0 occupies the most significant slot.
  function automatic int slot_offset(input int k, input int nodes, input int dw);
    return (nodes - 1 - k) * dw;
  endfunction

endpackage

// File: rtl/logit_frame_slot.sv
// Output holding register for one packed logit frame on a valid/ready interface.
// Ports:
//  clk        in   clock, posedge
//  reset      in   synchronous, active-low reset
//  load       in   capture load_data this cycle (only asserted when the slot is free)
//  load_data  in   FRAME_W packed frame to present
//  out_ready  in   consumer takes the frame when out_valid is high
//  out_valid  out  frame held and valid
//  out_data   out  FRAME_W packed frame; stable while out_valid && !out_ready
module logit_frame_slot #(
  parameter int FRAME_W = 160
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               load,
  input  logic [FRAME_W-1:0] load_data,
  input  logic               out_ready,
  output logic               out_valid,
  output logic [FRAME_W-1:0] out_data
);

  logic               valid_q, valid_d;
  logic [FRAME_W-1:0] data_q, data_d;

  // Next-state for the holding register: a load wins, otherwise a taken frame empties the slot.
  always_comb begin
    valid_d = valid_q;
    data_d  = data_q;
    if (load) begin
      valid_d = 1'b1;
      data_d  = load_data;
    end else if (out_ready) begin
      valid_d = 1'b0;
    end else begin
      valid_d = valid_q;
    end
  end

  // Holding register flops with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!reset) begin
      valid_q <= 1'b0;
      data_q  <= {FRAME_W{1'b0}};
    end else begin
      valid_q <= valid_d;
      data_q  <= data_d;
    end
  end

  assign out_valid = valid_q;
  assign out_data  = data_q;

endmodule

// File: rtl/logit_packer.sv
// Collects one logit per valid/ready beat and presents NODES of them as one packed frame
// for the classifier. Beat 0 lands in the most significant slot.
// Ports:
//  clk        in   clock, posedge
//  reset      in   synchronous, active-low reset
//  in_valid   in   logit beat valid
//  in_ready   out  packer accepts a beat this cycle
//  in_data    in   DATA_WIDTH signed logit (passed bit-exact)
//  in_last    in   producer marks final beat; early in_last aborts the frame
//  out_valid  out  packed frame valid
//  out_ready  in   classifier consumes frame
//  out_data   out  DATA_WIDTH*NODES packed frame
//  frame_err  out  one-cycle pulse when a frame is aborted by early in_last
//  err_cnt    out  8-bit saturating aborted-frame count
// Build option: define LOGIT_PACKER_ERR_CNT_EN to add err_cnt and its counter.
module logit_packer
  import cnn_pkg::*;
#(
  parameter int DATA_WIDTH = cnn_pkg::DATA_WIDTH,
  parameter int NODES      = cnn_pkg::NODES,
  parameter int CNT_W      = cnn_pkg::CNT_W
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_WIDTH-1:0]       in_data,
  input  logic                        in_last,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_WIDTH*NODES-1:0] out_data,
  output logic                        frame_err
`ifdef LOGIT_PACKER_ERR_CNT_EN
  ,
  output logic [7:0]                  err_cnt
`endif
);

  localparam int FRAME_W = DATA_WIDTH * NODES;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NODES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  packer_state_e      state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [FRAME_W-1:0] asm_q, asm_d;
  logic               frame_err_q, frame_err_d;
  logic               in_ready_q, in_ready_d;

  logic               slot_free_s;
  logic               beat_s;
  logic               load_s;
  logic [FRAME_W-1:0] load_data_s;
  logic [FRAME_W-1:0] filled_s;

  // FSM, beat counter and assembly register next-state.
  always_comb begin
    slot_free_s = !out_valid || out_ready;
    beat_s      = in_valid && in_ready_q;
    state_d     = state_q;
    cnt_d       = cnt_q;
    asm_d       = asm_q;
    frame_err_d = 1'b0;
    load_s      = 1'b0;
    load_data_s = asm_q;
    // Assembly image with the current beat written into its slot.
    filled_s    = asm_q;
    filled_s[slot_offset(int'(cnt_q), NODES, DATA_WIDTH) +: DATA_WIDTH] = in_data;
    case (state_q)
      FILL: begin
        if (beat_s) begin
          // The count decides completion; a missing in_last on the final beat is tolerated.
          if (cnt_q == LAST_CNT) begin
            cnt_d = {CNT_W{1'b0}};
            if (slot_free_s) begin
              load_s      = 1'b1;
              load_data_s = filled_s;
            end else begin
              asm_d   = filled_s;
              state_d = WAIT;
            end
          end else if (in_last) begin
            cnt_d       = {CNT_W{1'b0}};
            frame_err_d = 1'b1;
          end else begin
            asm_d = filled_s;
            cnt_d = cnt_q + CNT_ONE;
          end
        end else begin
          state_d = FILL;
        end
      end
      WAIT: begin
        if (slot_free_s) begin
          load_s      = 1'b1;
          load_data_s = asm_q;
          state_d     = FILL;
        end else begin
          state_d = WAIT;
        end
      end
      default: begin
        state_d = FILL;
        cnt_d   = {CNT_W{1'b0}};
      end
    endcase
    in_ready_d = (state_d == FILL);
  end

  // FSM, counter, assembly and registered status outputs.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q     <= FILL;
      cnt_q       <= {CNT_W{1'b0}};
      asm_q       <= {FRAME_W{1'b0}};
      frame_err_q <= 1'b0;
      in_ready_q  <= 1'b1;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      asm_q       <= asm_d;
      frame_err_q <= frame_err_d;
      in_ready_q  <= in_ready_d;
    end
  end

  logit_frame_slot #(
    .FRAME_W (FRAME_W)
  ) u_slot (
    .clk       (clk),
    .reset     (reset),
    .load      (load_s),
    .load_data (load_data_s),
    .out_ready (out_ready),
    .out_valid (out_valid),
    .out_data  (out_data)
  );

  assign in_ready  = in_ready_q;
  assign frame_err = frame_err_q;

`ifdef LOGIT_PACKER_ERR_CNT_EN
  logic [7:0] err_cnt_q, err_cnt_d;

  // Saturating count of aborted frames, bumped on the edge that raises frame_err.
  always_comb begin
    err_cnt_d = err_cnt_q;
    if (frame_err_d && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end else begin
      err_cnt_d = err_cnt_q;
    end
  end

  // Error counter flop; only reset clears it.
  always_ff @(posedge clk) begin
    if (!reset) begin
      err_cnt_q <= 8'd0;
    end else begin
      err_cnt_q <= err_cnt_d;
    end
  end

  assign err_cnt = err_cnt_q;
`endif

endmodule

// File: tb/tb_logit_packer.sv
// Self-checking bench for logit_packer: directed scenarios plus a randomized run checked
// against a frame-queue reference model.
module tb_logit_packer;

  localparam int DW = 16;
  localparam int N  = 10;
  localparam int FW = DW * N;

  logic          clk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [DW-1:0] in_data;
  logic          in_last;
  logic          out_valid;
  logic          out_ready;
  logic [FW-1:0] out_data;
  logic          frame_err;
`ifdef LOGIT_PACKER_ERR_CNT_EN
  logic [7:0]    err_cnt;
`endif

  int tests = 0;
  int fails = 0;

  logit_packer dut (
    .clk       (clk),
    .reset     (reset),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_data   (in_data),
    .in_last   (in_last),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .frame_err (frame_err)
`ifdef LOGIT_PACKER_ERR_CNT_EN
    ,
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  // Reference packing: first logit ends up most significant.
  function automatic logic [FW-1:0] pack(input logic [DW-1:0] b [N]);
    logic [FW-1:0] f;
    f = {FW{1'b0}};
    for (int k = 0; k < N; k++) f = {f[FW-DW-1:0], b[k]};
    return f;
  endfunction

  // Classifier view: code 1..N of the largest signed logit (first one wins ties).
  function automatic int argmax_code(input logic [FW-1:0] f);
    logic signed [DW-1:0] best;
    logic signed [DW-1:0] v;
    logic [FW-1:0] t;
    int code;
    t = f;
    best = $signed(t[FW-1:FW-DW]);
    code = 1;
    for (int k = 0; k < N; k++) begin
      v = $signed(t[FW-1:FW-DW]);
      if (v > best) begin
        best = v;
        code = k + 1;
      end
      t = t << DW;
    end
    return code;
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_beats(output logic [DW-1:0] b [N]);
    for (int k = 0; k < N; k++) b[k] = DW'($urandom);
  endtask

  task automatic drive_beat(input logic [DW-1:0] d, input logic last);
    in_valid = 1'b1;
    in_data  = d;
    in_last  = last;
    tick();
    in_valid = 1'b0;
    in_last  = 1'b0;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  task automatic test_reset();
    in_valid = 1'b0; in_data = '0; in_last = 1'b0; out_ready = 1'b0;
    apply_reset();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL reset_out_valid: got %b want 0", out_valid); end
    tests++; if (out_data !== {FW{1'b0}}) begin fails++; $display("FAIL reset_out_data: got %h want 0", out_data); end
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL reset_frame_err: got %b want 0", frame_err); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL reset_in_ready: got %b want 1", in_ready); end
  endtask

  task automatic test_basic();
    logic [DW-1:0] b [N];
    logic [FW-1:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < N; k++) b[k] = DW'(k + 1);
    exp = pack(b);
    for (int k = 0; k < N - 1; k++) drive_beat(b[k], 1'b0);
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_early_valid: got %b want 0", out_valid); end
    drive_beat(b[N-1], 1'b1);
    tests++; if (out_valid !== 1'b1) begin fails++; $display("FAIL basic_valid: got %b want 1", out_valid); end
    tests++; if (out_data !== exp) begin fails++; $display("FAIL basic_data: got %h want %h", out_data, exp); end
    tests++; if (out_data[159:144] !== 16'd1) begin fails++; $display("FAIL basic_ms_slot: got %h want 0001", out_data[159:144]); end
    tests++; if (out_data[15:0] !== 16'd10) begin fails++; $display("FAIL basic_ls_slot: got %h want 000a", out_data[15:0]); end
    tests++; if (argmax_code(out_data) != 10) begin fails++; $display("FAIL basic_class: got %0d want 10", argmax_code(out_data)); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL basic_consumed: got %b want 0", out_valid); end
  endtask

  task automatic test_back_to_back();
    logic [DW-1:0] a [N];
    logic [DW-1:0] b [N];
    logic [FW-1:0] exp_a, exp_b;
    rand_beats(a); rand_beats(b);
    exp_a = pack(a); exp_b = pack(b);
    out_ready = 1'b0;
    for (int k = 0; k < N; k++) drive_beat(a[k], k == N - 1);
    tests++; if (out_valid !== 1'b1 || out_data !== exp_a) begin fails++; $display("FAIL b2b_a_loaded: got %b/%h want 1/%h", out_valid, out_data, exp_a); end
    for (int k = 0; k < N - 1; k++) begin
      drive_beat(b[k], 1'b0);
      tests++; if (out_data !== exp_a || in_ready !== 1'b1) begin fails++; $display("FAIL b2b_fill_while_held: got %h rdy %b want %h rdy 1", out_data, in_ready, exp_a); end
    end
    drive_beat(b[N-1], 1'b1);
    tests++; if (in_ready !== 1'b0) begin fails++; $display("FAIL b2b_stall: got in_ready %b want 0", in_ready); end
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_data = DW'($urandom);
      tick();
      tests++; if (out_valid !== 1'b1 || out_data !== exp_a || in_ready !== 1'b0) begin fails++; $display("FAIL b2b_hold_a: got %b/%h rdy %b want 1/%h rdy 0", out_valid, out_data, in_ready, exp_a); end
    end
    in_valid = 1'b0;
    out_ready = 1'b1;
    tick();
    tests++; if (out_valid !== 1'b1 || out_data !== exp_b) begin fails++; $display("FAIL b2b_b_loaded: got %b/%h want 1/%h", out_valid, out_data, exp_b); end
    tests++; if (in_ready !== 1'b1) begin fails++; $display("FAIL b2b_ready_back: got %b want 1", in_ready); end
    tick();
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL b2b_drained: got %b want 0", out_valid); end
  endtask

  task automatic test_early_last();
    logic [DW-1:0] b [N];
    logic [FW-1:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 3; k++) drive_beat(DW'($urandom), 1'b0);
    drive_beat(DW'($urandom), 1'b1);
    tests++; if (frame_err !== 1'b1) begin fails++; $display("FAIL early_err_pulse: got %b want 1", frame_err); end
    tests++; if (out_valid !== 1'b0) begin fails++; $display("FAIL early_no_valid: got %b want 0", out_valid); end
    tick();
    tests++; if (frame_err !== 1'b0) begin fails++; $display("FAIL early_err_one_cycle: got %b want 0", frame_err); end
    rand_beats(b); exp = pack(b);
    for (int k = 0; k < N; k++) drive_beat(b[k], k == N - 1);
    tests++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++; $display("FAIL early_next_frame: got %b/%h want 1/%h", out_valid, out_data, exp); end
    tick();
  endtask

  task automatic test_negative();
    logic [DW-1:0] b [N];
    logic [FW-1:0] exp;
    out_ready = 1'b1;
    rand_beats(b);
    b[0] = 16'h8000; b[N-1] = 16'hFFFF;
    exp = pack(b);
    for (int k = 0; k < N; k++) drive_beat(b[k], 1'b0);  // in_last deliberately missing
    tests++; if (out_data[159:144] !== 16'h8000) begin fails++; $display("FAIL neg_ms: got %h want 8000", out_data[159:144]); end
    tests++; if (out_data[15:0] !== 16'hFFFF) begin fails++; $display("FAIL neg_ls: got %h want ffff", out_data[15:0]); end
    tests++; if (out_valid !== 1'b1 || out_data !== exp || frame_err !== 1'b0) begin fails++; $display("FAIL neg_frame: got %b/%h err %b want 1/%h err 0", out_valid, out_data, frame_err, exp); end
    tick();
  endtask

  task automatic test_reset_mid();
    logic [DW-1:0] b [N];
    logic [FW-1:0] exp;
    out_ready = 1'b1;
    for (int k = 0; k < 5; k++) drive_beat(DW'($urandom), 1'b0);
    reset = 1'b0; tick(); reset = 1'b1;
    tests++; if (out_valid !== 1'b0 || out_data !== {FW{1'b0}}) begin fails++; $display("FAIL rstmid_clear: got %b/%h want 0/0", out_valid, out_data); end
    rand_beats(b); exp = pack(b);
    for (int k = 0; k < N; k++) drive_beat(b[k], k == N - 1);
    tests++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++; $display("FAIL rstmid_frame: got %b/%h want 1/%h", out_valid, out_data, exp); end
    out_ready = 1'b0;
    tick();
    rand_beats(b);
    for (int k = 0; k < N; k++) drive_beat(b[k], k == N - 1);
    reset = 1'b0; tick(); reset = 1'b1;
    tests++; if (out_valid !== 1'b0 || out_data !== {FW{1'b0}} || in_ready !== 1'b1) begin fails++; $display("FAIL rsthold_clear: got %b/%h rdy %b want 0/0 rdy 1", out_valid, out_data, in_ready); end
    out_ready = 1'b1;
    rand_beats(b); exp = pack(b);
    for (int k = 0; k < N; k++) drive_beat(b[k], k == N - 1);
    tests++; if (out_valid !== 1'b1 || out_data !== exp) begin fails++; $display("FAIL rsthold_frame: got %b/%h want 1/%h", out_valid, out_data, exp); end
    tick();
  endtask

  // Model: q holds frames completed but not yet consumed (front = presented frame);
  // cur holds the beats of the frame being collected.
  task automatic test_random();
    logic [FW-1:0] q [$];
    logic [DW-1:0] cur [$];
    logic [FW-1:0] f;
    logic err_exp;
    logic consumed, accepted;
    apply_reset();
    err_exp = 1'b0;
    for (int cyc = 0; cyc < 1500; cyc++) begin
      @(posedge clk);
      #1;
      in_valid  = ($urandom_range(0, 3) != 0);
      in_data   = DW'($urandom);
      in_last   = (cur.size() == N - 1) ? 1'($urandom_range(0, 1)) : ($urandom_range(0, 24) == 0);
      out_ready = ($urandom_range(0, 2) != 0);
      @(negedge clk);
      tests++; if (out_valid !== (q.size() > 0)) begin fails++; $display("FAIL rand_out_valid c%0d: got %b want %b", cyc, out_valid, q.size() > 0); end
      tests++; if (in_ready !== (q.size() < 2)) begin fails++; $display("FAIL rand_in_ready c%0d: got %b want %b", cyc, in_ready, q.size() < 2); end
      tests++; if (frame_err !== err_exp) begin fails++; $display("FAIL rand_frame_err c%0d: got %b want %b", cyc, frame_err, err_exp); end
      if (q.size() > 0) begin
        tests++; if (out_data !== q[0]) begin fails++; $display("FAIL rand_out_data c%0d: got %h want %h", cyc, out_data, q[0]); end
      end
      consumed = (q.size() > 0) && out_ready;
      accepted = in_valid && (q.size() < 2);
      err_exp = 1'b0;
      if (consumed) void'(q.pop_front());
      if (accepted) begin
        if (in_last && cur.size() < N - 1) begin
          cur.delete();
          err_exp = 1'b1;
        end else begin
          cur.push_back(in_data);
          if (cur.size() == N) begin
            f = {FW{1'b0}};
            foreach (cur[i]) f = {f[FW-DW-1:0], cur[i]};
            q.push_back(f);
            cur.delete();
          end
        end
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    tick(); tick(); tick();
  endtask

`ifdef LOGIT_PACKER_ERR_CNT_EN
  task automatic test_err_cnt();
    int want;
    apply_reset();
    out_ready = 1'b1;
    tests++; if (err_cnt !== 8'd0) begin fails++; $display("FAIL errcnt_reset: got %0d want 0", err_cnt); end
    for (int i = 0; i < 300; i++) begin
      in_valid = 1'b1; in_last = 1'b1; in_data = DW'($urandom);
      tick();
      want = (i + 1 > 255) ? 255 : i + 1;
      tests++; if (err_cnt !== 8'(want) || frame_err !== 1'b1) begin fails++; $display("FAIL errcnt_step%0d: got %0d err %b want %0d err 1", i, err_cnt, frame_err, want); end
    end
    in_valid = 1'b0; in_last = 1'b0;
    tick();
    tests++; if (err_cnt !== 8'hFF) begin fails++; $display("FAIL errcnt_sat: got %h want ff", err_cnt); end
  endtask
`endif

  initial begin
    reset = 1'b0;
    test_reset();
    test_basic();
    test_back_to_back();
    test_early_last();
    test_negative();
    test_reset_mid();
    test_random();
`ifdef LOGIT_PACKER_ERR_CNT_EN
    test_err_cnt();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
